// File: rtl/grant_scheduler_4.sv
// Round-robin grant scheduler for four requesters sharing one 2-to-4 decoder.
// Grants last at most MAX_HOLD cycles and are always followed by one enable-low gap cycle.
module grant_scheduler_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic       en,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       timeout
);

  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic       en_q, en_d;
  logic       timeout_q, timeout_d;

  logic       pick_valid;
  logic [1:0] pick_idx;
  logic [1:0] cand;
  logic       release_now;
  logic       expire_now;

  // Scan from the highest offset down so the requester closest to ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = ptr_q;
    cand       = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign release_now = done[sel_q] | ~req[sel_q];
  assign expire_now  = (cnt_q == HoldLast);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    en_d      = en_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle, StGap: begin
        if (pick_valid) begin
          state_d = StGrant;
          sel_d   = pick_idx;
          en_d    = 1'b1;
          cnt_d   = 8'd0;
        end else begin
          state_d = StIdle;
          en_d    = 1'b0;
        end
      end
      StGrant: begin
        if (release_now || expire_now) begin
          state_d   = StGap;
          en_d      = 1'b0;
          ptr_d     = sel_q + 2'd1;
          // Only a pure expiry counts as a timeout.
          timeout_d = expire_now & ~release_now;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        en_d    = 1'b0;
      end
    endcase
    gnt_d = en_d ? (4'b0001 << sel_d) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= 2'd0;
      sel_q     <= 2'd0;
      cnt_q     <= 8'd0;
      gnt_q     <= 4'b0000;
      en_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      en_q      <= en_d;
      timeout_q <= timeout_d;
    end
  end

  assign en      = en_q;
  assign sel     = sel_q;
  assign gnt     = gnt_q;
  assign busy    = (state_q == StGrant);
  assign timeout = timeout_q;

endmodule

// File: doc/grant_scheduler_4.md
GRANT_SCHEDULER_4 -- requirements
Module: grant_scheduler_4

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive cycles one requester may hold a grant (legal range 1..255).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  4  request per requester; held high while the requester wants the shared decoder.
REQ-005 Port: done  input  4  per-requester release pulse; only the bit of the current grantee is honoured.
REQ-006 Port: en  output  1  registered enable driving the shared 2-to-4 decoder's enable input.
REQ-007 Port: sel  output  2  registered select driving the decoder's 2-bit address input; index of the current grantee.
REQ-008 Port: gnt  output  4  registered one-hot grant; at all times equals the 2-to-4 decode of (en, sel), 0000 when en=0.
REQ-009 Port: busy  output  1  high while in GRANT state.
REQ-010 Port: timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Function
REQ-011 The block SHALL implement three states: IDLE, GRANT, GAP; the reset state is IDLE.
REQ-012 The block SHALL keep a 2-bit round-robin pointer ptr; arbitration picks the first asserted req bit at ptr, ptr+1, ... modulo 4 (3 wraps to 0).
REQ-013 IDLE: if any req bit is high at an edge, the next state SHALL be GRANT with sel = the arbitrated index, en=1, gnt one-hot, busy=1; otherwise remain in IDLE with en=0.
REQ-014 Grant latency SHALL be exactly one cycle: req sampled high at edge N gives gnt visible after edge N.
REQ-015 GRANT: a 8-bit hold counter SHALL clear on entry and increment once per cycle in GRANT.
REQ-016 GRANT exits to GAP when any of the following holds at an edge: done[sel]=1, req[sel]=0, or hold counter = MAX_HOLD-1; on exit en=0, gnt=0000, busy=0, ptr=sel+1 mod 4.
REQ-017 A grant SHALL therefore last at most MAX_HOLD cycles; with MAX_HOLD=1 every grant lasts exactly one cycle.
REQ-018 timeout SHALL pulse high for the single cycle following an exit caused only by counter expiry; when done[sel] or req[sel]=0 coincides with expiry, timeout SHALL stay low.
REQ-019 GAP: lasts exactly one cycle with en=0; the block SHALL arbitrate using the updated ptr, going to GRANT if any req is high, else IDLE.
REQ-020 Consecutive grants SHALL therefore be separated by exactly one idle-enable cycle, and two grants never overlap.
REQ-021 done bits of non-granted requesters and done in IDLE/GAP SHALL be ignored.
REQ-022 sel SHALL hold its last value while en=0; gnt SHALL never be non-zero with en=0.
REQ-023 A requester that is sole requester SHALL be re-granted after its GAP cycle; no requester with req held continuously waits more than 3 grants.

Reset
REQ-024 While rst_n=0, outputs SHALL be immediately en=0, sel=00, gnt=0000, busy=0, timeout=0; state=IDLE, ptr=0, counter=0.
REQ-025 Reset asserted mid-grant SHALL abort the grant asynchronously; after release, arbitration restarts from ptr=0 with no memory of the aborted grant.
REQ-026 The first edge after rst_n rises SHALL be a normal IDLE arbitration edge.

Verification
REQ-027 Reset: rst_n=0 with req=1111 -> en=0, sel=00, gnt=0000, busy=0, timeout=0 for the whole reset interval.
REQ-028 Single request: req=0100 after reset -> after one edge gnt=0100, sel=10, en=1; pulse done[2] -> next edge gnt=0000, then one GAP cycle, then IDLE once req drops.
REQ-029 Fairness: req=1111 held, each grantee pulses done on its first granted cycle -> grant order 0,1,2,3,0 with one en=0 cycle between each.
REQ-030 Timeout: MAX_HOLD=8, req=0010 held, no done -> gnt=0010 for exactly 8 cycles, timeout=1 for one cycle, GAP, then gnt=0010 re-granted.
REQ-031 Ignored done: gnt=0001, done=1110 pulsed -> grant continues unchanged, no state change.
REQ-032 Reset mid-grant: gnt=1000, rst_n pulled low between edges -> gnt=0000 without waiting for clk; after release with req=1111 -> first grant gnt=0001.
